// File: rtl/fas_pkg.sv
// Shared constants and arithmetic helpers for the FAS front-end chain (FIR now, FFT later).
package fas_pkg;

   localparam int ACC_MAX_W = 64;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Tap-0 value of the identity bank; callers truncate to their coefficient width.
   function automatic logic [ACC_MAX_W-1:0] identity_c0(input int frac_w);
      return ACC_MAX_W'(1) << frac_w;
   endfunction

   function automatic logic signed [ACC_MAX_W-1:0] round_sat(
      input logic signed [ACC_MAX_W-1:0] acc,
      input int                          frac_w,
      input int                          out_w
   );
      logic signed [ACC_MAX_W-1:0] r;
      logic signed [ACC_MAX_W-1:0] hi;
      logic signed [ACC_MAX_W-1:0] lo;
      r  = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/fir_mac_tree.sv
// Two-stage MAC: registered tap products, then registered rounded/saturated sum.
module fir_mac_tree
   import fas_pkg::*;
#(
   parameter int TAPS   = 32,
   parameter int DATA_W = 16,
   parameter int COEF_W = 20,
   parameter int FRAC_W = 16,
   parameter int OUT_W  = 16
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           in_valid,
   input  logic [TAPS-1:0][DATA_W-1:0]    x,
   input  logic [TAPS-1:0][COEF_W-1:0]    coef,
   output logic                           out_valid,
   output logic [OUT_W-1:0]               out_d
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + clog2(TAPS);

   logic signed [PROD_W-1:0] prod [TAPS];
   logic                     prod_valid;
   logic signed [ACC_W-1:0]  acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TAPS; i++) prod[i] <= '0;
         prod_valid <= 1'b0;
      end else begin
         prod_valid <= in_valid && !flush;
         if (in_valid) begin
            for (int i = 0; i < TAPS; i++)
               prod[i] <= PROD_W'($signed(x[i])) * PROD_W'($signed(coef[i]));
         end
      end
   end

   always_comb begin
      acc = '0;
      for (int i = 0; i < TAPS; i++) acc = acc + ACC_W'(prod[i]);
   end

   // fir_d only moves on a delivered result, so it holds through gaps and flushes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_d     <= '0;
      end else begin
         out_valid <= prod_valid && !flush;
         if (prod_valid && !flush)
            out_d <= OUT_W'(round_sat(ACC_MAX_W'(acc), FRAC_W, OUT_W));
      end
   end

endmodule

// File: rtl/fir_stream_param.sv
// Streaming FIR with double-buffered coefficient bank and FFT-frame tagging of each output.
module fir_stream_param
   import fas_pkg::*;
#(
   parameter int TAPS   = 32,
   parameter int DATA_W = 16,
   parameter int COEF_W = 20,
   parameter int FRAC_W = 16,
   parameter int OUT_W  = 16,
   parameter int FFT_N  = 16
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       data_valid,
   input  logic [DATA_W-1:0]          data,
   input  logic                       flush,
   input  logic                       coef_wr,
   input  logic [clog2(TAPS)-1:0]     coef_addr,
   input  logic [COEF_W-1:0]          coef_wdata,
   input  logic                       coef_swap,
   output logic                       fir_valid,
   output logic [OUT_W-1:0]           fir_d,
   output logic [clog2(FFT_N)-1:0]    fft_idx,
   output logic                       frame_last
);

   localparam int AW = clog2(TAPS);
   localparam int IW = clog2(FFT_N);
   localparam logic [AW:0]   FILL_MAX  = (AW+1)'(TAPS);
   localparam logic [AW:0]   FILL_LAST = (AW+1)'(TAPS - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(FFT_N - 1);
   localparam logic [TAPS-1:0][COEF_W-1:0] IDENT_BANK = (TAPS*COEF_W)'(identity_c0(FRAC_W));

   logic [TAPS-1:0][DATA_W-1:0] x_line;
   logic [TAPS-1:0][COEF_W-1:0] shadow;
   logic [TAPS-1:0][COEF_W-1:0] active;
   logic [AW:0]                 fill_cnt;
   logic                        x_valid;
   logic                        addr_ok;

   if ((1 << AW) == TAPS) begin : g_addr_full
      assign addr_ok = 1'b1;
   end else begin : g_addr_part
      assign addr_ok = ({1'b0, coef_addr} < FILL_MAX);
   end

   // x_valid marks samples past warm-up; earlier samples only fill the delay line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_line   <= '0;
         fill_cnt <= '0;
         x_valid  <= 1'b0;
      end else if (flush) begin
         x_line   <= '0;
         fill_cnt <= '0;
         x_valid  <= 1'b0;
      end else if (data_valid) begin
         x_line  <= {x_line[TAPS-2:0], data};
         x_valid <= (fill_cnt >= FILL_LAST);
         if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;
      end else begin
         x_valid <= 1'b0;
      end
   end

   // Non-blocking copy means a same-edge write is not seen by the swap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= IDENT_BANK;
         active <= IDENT_BANK;
      end else begin
         if (coef_swap) active <= shadow;
         if (coef_wr && addr_ok) shadow[coef_addr] <= coef_wdata;
      end
   end

   fir_mac_tree #(
      .TAPS   (TAPS),
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .FRAC_W (FRAC_W),
      .OUT_W  (OUT_W)
   ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (x_valid),
      .x         (x_line),
      .coef      (active),
      .out_valid (fir_valid),
      .out_d     (fir_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            fft_idx <= '0;
      else if (flush)     fft_idx <= '0;
      else if (fir_valid) fft_idx <= fft_idx + 1'b1;
   end

   assign frame_last = fir_valid && (fft_idx == IDX_LAST);

endmodule

// File: tb/tb_fir_stream_param.sv
// Directed bench for fir_stream_param: latency, coefficients, saturation, rounding, frames, flush, reset.
module tb_fir_stream_param;

   localparam int TAPS   = 32;
   localparam int DATA_W = 16;
   localparam int COEF_W = 24;
   localparam int FRAC_W = 16;
   localparam int OUT_W  = 16;
   localparam int FFT_N  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              data_valid;
   logic [DATA_W-1:0] data;
   logic              flush;
   logic              coef_wr;
   logic [4:0]        coef_addr;
   logic [COEF_W-1:0] coef_wdata;
   logic              coef_swap;
   logic              fir_valid;
   logic [OUT_W-1:0]  fir_d;
   logic [3:0]        fft_idx;
   logic              frame_last;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t_mark;

   logic signed [OUT_W-1:0] q_d[$];
   logic [3:0]              q_idx[$];
   logic                    q_last[$];
   int                      q_cyc[$];

   fir_stream_param #(
      .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
      .FRAC_W(FRAC_W), .OUT_W(OUT_W), .FFT_N(FFT_N)
   ) dut (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .flush(flush),
      .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap),
      .fir_valid(fir_valid), .fir_d(fir_d), .fft_idx(fft_idx), .frame_last(frame_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fir_valid === 1'b1) begin
         q_d.push_back($signed(fir_d));
         q_idx.push_back(fft_idx);
         q_last.push_back(frame_last);
         q_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [63:0] qd(input int j);
      if (j < q_d.size()) return 64'(q_d[j]);
      return 'x;
   endfunction

   function automatic logic signed [63:0] qi(input int j);
      if (j < q_idx.size()) return 64'(q_idx[j]);
      return 'x;
   endfunction

   function automatic logic signed [63:0] ql(input int j);
      if (j < q_last.size()) return 64'(q_last[j]);
      return 'x;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] v);
      data       = v;
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
   endtask

   task automatic wr_coef(input logic [4:0] a, input logic [COEF_W-1:0] v);
      coef_addr  = a;
      coef_wdata = v;
      coef_wr    = 1'b1;
      step();
      coef_wr    = 1'b0;
   endtask

   task automatic do_swap();
      coef_swap = 1'b1;
      step();
      coef_swap = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic clrq();
      q_d.delete();
      q_idx.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   initial begin
      rst = 1'b1; data_valid = 1'b0; data = '0; flush = 1'b0;
      coef_wr = 1'b0; coef_addr = '0; coef_wdata = '0; coef_swap = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_valid", 64'(fir_valid), 64'(0));
      chk("rst_d",     64'(fir_d),     64'(0));
      chk("rst_idx",   64'(fft_idx),   64'(0));
      chk("rst_last",  64'(frame_last), 64'(0));

      // identity bank: output equals the newest sample, first valid 3 cycles after sample 32
      clrq();
      t_mark = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 32) t_mark = cyc;
         send(16'(i));
      end
      repeat (4) step();
      chk("t1_count", 64'(q_d.size()), 64'(9));
      chk("t1_latency", (q_cyc.size() > 0) ? 64'(q_cyc[0]) : 'x, 64'(t_mark + 3));
      for (int j = 0; j < 9; j++) begin
         chk("t1_d",   qd(j), 64'(32 + j));
         chk("t1_idx", qi(j), 64'(j));
      end
      chk("t1_hold", 64'($signed(fir_d)), 64'(40));

      // ramp coefficients, impulse response after zero pre-fill
      for (int i = 0; i < TAPS; i++) wr_coef(5'(i), COEF_W'(i << 16));
      do_swap();
      do_flush();
      clrq();
      for (int i = 0; i < 31; i++) send(16'd0);
      send(16'd1);
      for (int i = 0; i < 31; i++) send(16'd0);
      repeat (4) step();
      chk("t2_count", 64'(q_d.size()), 64'(32));
      for (int j = 0; j < 32; j++) chk("t2_d", qd(j), 64'(j));

      // saturation on both rails
      for (int i = 0; i < TAPS; i++) wr_coef(5'(i), 24'h07FFFF);
      do_swap();
      do_flush();
      clrq();
      for (int i = 0; i < 34; i++) send(16'h7FFF);
      repeat (4) step();
      chk("t3_pos_count", 64'(q_d.size()), 64'(3));
      chk("t3_pos_first", qd(0), 64'(32767));
      chk("t3_pos_last",  qd(2), 64'(32767));
      clrq();
      for (int i = 0; i < 32; i++) send(16'h8000);
      repeat (4) step();
      chk("t3_neg_count", 64'(q_d.size()), 64'(32));
      chk("t3_mid16",     qd(15), 64'(-128));
      chk("t3_neg_last",  qd(31), 64'(-32768));

      // frame index across 64 outputs with input gaps
      do_flush();
      clrq();
      for (int n = 0; n < 95; n++) begin
         send(16'(n));
         if (n % 3 == 2) step();
      end
      repeat (4) step();
      chk("t4_count", 64'(q_d.size()), 64'(64));
      for (int j = 0; j < 64; j++) begin
         chk("t4_idx",  qi(j), 64'(j % 16));
         chk("t4_last", ql(j), 64'((j % 16) == 15));
      end

      // async reset mid-stream
      for (int i = 0; i < 5; i++) send(16'd7);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", 64'(fir_valid),  64'(0));
      chk("ar_d",     64'(fir_d),      64'(0));
      chk("ar_idx",   64'(fft_idx),    64'(0));
      chk("ar_last",  64'(frame_last), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // flush with a simultaneous sample: dropped, warm-up restarts, fft_idx restarts
      clrq();
      for (int v = 100; v < 140; v++) send(16'(v));
      flush = 1'b1; data = 16'd999; data_valid = 1'b1;
      step();
      flush = 1'b0; data_valid = 1'b0;
      chk("t5_valid_after_flush", 64'(fir_valid), 64'(0));
      chk("t5_d_hold",            64'($signed(fir_d)), 64'(137));
      chk("t5_idx_after_flush",   64'(fft_idx), 64'(0));
      clrq();
      for (int v = 200; v < 240; v++) send(16'(v));
      repeat (4) step();
      chk("t5_count", 64'(q_d.size()), 64'(9));
      chk("t5_first", qd(0), 64'(231));
      chk("t5_idx0",  qi(0), 64'(0));
      chk("t5_last",  qd(8), 64'(239));

      // write+swap same cycle, then a swap landing mid-stream
      wr_coef(5'd0, 24'h020000);
      coef_addr = 5'd0; coef_wdata = 24'h030000; coef_wr = 1'b1; coef_swap = 1'b1;
      step();
      coef_wr = 1'b0; coef_swap = 1'b0;
      do_flush();
      clrq();
      for (int i = 1; i <= 40; i++) begin
         if (i == 35) coef_swap = 1'b1;
         send(16'd5);
         coef_swap = 1'b0;
      end
      repeat (4) step();
      chk("t6_count",      64'(q_d.size()), 64'(9));
      chk("t6_old_first",  qd(0), 64'(10));
      chk("t6_old_edge",   qd(2), 64'(10));
      chk("t6_new_edge",   qd(3), 64'(15));
      chk("t6_new_last",   qd(8), 64'(15));

      // half-up rounding with c[0]=0.5
      wr_coef(5'd0, 24'h008000);
      do_swap();
      do_flush();
      clrq();
      for (int i = 0; i < 32; i++) send(16'd3);
      send(-16'sd3);
      send(16'd1);
      send(-16'sd1);
      send(16'd0);
      repeat (4) step();
      chk("t7_count", 64'(q_d.size()), 64'(5));
      chk("t7_p1p5",  qd(0), 64'(2));
      chk("t7_m1p5",  qd(1), 64'(-1));
      chk("t7_p0p5",  qd(2), 64'(1));
      chk("t7_m0p5",  qd(3), 64'(0));
      chk("t7_zero",  qd(4), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
